spi_master_arbiter: RTL and testbench
=====================================

# spi_master_arbiter

Sequencer and round-robin arbiter that shares one SPI master byte engine between `NUM_REQ` requesters. It accepts byte-stream transactions from each requester over a valid/ready handshake and owns that requester's chip select for the whole transaction. It issues one start pulse per byte to the master core and returns each received byte. It sits between the system-side clients and the SPI master core in the combined top.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..4.
- `CS_SETUP`, 2: clk cycles from `cs_n` falling to the first `mst_start`, minimum 1.
- `CS_HOLD`, 2: clk cycles from the last `mst_done` to `cs_n` rising, minimum 1.
- `CS_GAP`, 1: minimum clk cycles with all `cs_n` high between transactions, minimum 1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NUM_REQ  requester i has a byte to send.
- `req_data`  in  8*NUM_REQ  byte for requester i, in slice [8i+7:8i].
- `req_last`  in  NUM_REQ  byte is the final byte of the transaction.
- `req_ready`  out  NUM_REQ  byte accepted this cycle.
- `resp_valid`  out  NUM_REQ  one-cycle pulse: `resp_data` is valid for requester i.
- `resp_data`  out  8  received byte, shared by all requesters.
- `cs_n`  out  NUM_REQ  chip selects, active-low, registered.
- `mst_start`  out  1  one-cycle start pulse to the master core.
- `mst_tx_data`  out  8  byte to shift out; valid while `mst_start` is high.
- `mst_busy`  in  1  master core is shifting.
- `mst_done`  in  1  one-cycle pulse: byte complete, `mst_rx_data` is valid.
- `mst_rx_data`  in  8  received byte.

## Operation
FSM states are IDLE, SETUP, START, WAIT, HOLD and GAP. The granted index is `g`.
- **IDLE:** if any `req_valid` is high, the round-robin arbiter picks `g`. The search starts at `last_grant+1` modulo NUM_REQ. Next cycle: `cs_n[g]`=0, state SETUP, counter loaded with CS_SETUP-1.
- **SETUP:** counts down to 0, then goes to START.
- **START:** waits for `req_valid[g]` and `!mst_busy`. When both hold, combinationally in the same cycle:
  - `mst_start`=1, `mst_tx_data`=`req_data[g]`, `req_ready[g]`=1;
  - `req_last[g]` is latched;
  - next state is WAIT.

  If `req_valid[g]` stays low, the FSM stalls in START with CS held low; there is no timeout.
- **WAIT:** on `mst_done`, the next cycle has `resp_valid[g]`=1 and `resp_data`=`mst_rx_data`. Next state is HOLD if the latched last flag is set, otherwise START.
- **HOLD:** counts CS_HOLD cycles, then `cs_n[g]`=1, `last_grant`=g, state GAP.
- **GAP:** counts CS_GAP cycles, then goes to IDLE.
- Grant is locked for the whole transaction. Requests from other requesters are ignored until IDLE.
- `req_valid` of requesters that are not granted is never acknowledged. `req_ready` is only ever asserted for `g`.
- `mst_done` outside WAIT is ignored and produces no `resp_valid`.
- At most one bit of `cs_n` is low at any time.

## Timing
- Reset values:
  - FSM in IDLE; `cs_n` all ones; `last_grant`=NUM_REQ-1, so requester 0 wins first.
  - `resp_valid`=0, `resp_data`=0.
  - `mst_start`=0, `mst_tx_data`=0, `req_ready`=0.
- Reset asserted mid-transaction forces the reset values immediately (async), including deasserting `cs_n`. The master core shares `rst`.
- Request to CS low: 1 cycle, request seen in IDLE then `cs_n` low next edge.
- CS low to first `mst_start`: CS_SETUP cycles.
- `mst_done` to `resp_valid`: 1 cycle.
- Back-to-back bytes: the earliest next `mst_start` is 1 cycle after `mst_done`, because WAIT→START takes one edge.
- Last `mst_done` to `cs_n` high: CS_HOLD+1 cycles.
- `cs_n` high to the next `cs_n` low: at least CS_GAP+1 cycles.
- A single-byte transaction has `req_last` high on its first byte.
- `mst_start` and `req_ready[g]` are combinational outputs of START. They must never be high in the same cycle as a `cs_n` transition.

## Structure
- Package `spi_arb_pkg`:
  - state enum `spi_arb_state_t` (IDLE..GAP);
  - `SPI_BYTE_W`=8;
  - counter width constant `SPI_ARB_CNT_W`=4.
- Sub-module `rr_arbiter`:
  - inputs: request vector, `last_grant` index;
  - output: one-hot grant plus encoded index;
  - purely combinational.
- The top holds the FSM, the delay counter, `last_grant`, the latched last flag and the response register.

## Test plan
- **Single byte:** reset; requester 0 sends 0xA5 with last=1; core model returns 0x3C.
  - Required: `cs_n`=2'b10 for 2+1+byte+2 cycles.
  - Required: exactly one `mst_start` with `mst_tx_data`=0xA5.
  - Required: `resp_valid`=2'b01 with `resp_data`=0x3C.
  - Required: `cs_n` back to 2'b11 CS_HOLD+1 cycles after `mst_done`.
- **Multi-byte:** requester 1 sends 0x01, 0x02, 0x03 (last on 0x03).
  - Required: three starts in order, `cs_n[1]` continuously low, three `resp_valid[1]` pulses.
- **Contention:** both requesters hold valid from reset.
  - Required: requester 0 is served first, then requester 1, then requester 0 again.
  - Required: never both `cs_n` low; at least CS_GAP+1 cycles all-high between transactions.
- **Stall:** requester 0 drops `req_valid` after byte 1 for 10 cycles.
  - Required: FSM stays in START with `cs_n[0]`=0 and no `mst_start`.
  - Required: resumes on the next valid.
- **Reset mid-transaction:** assert `rst` during WAIT.
  - Required: `cs_n`=all ones and `req_ready`/`mst_start`=0 immediately.
  - Required: after release, requester 0 is granted first.
- **Spurious `mst_done`:** pulse `mst_done` while in IDLE.
  - Required: no `resp_valid` and no state change.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter slice.
package spi_arb_pkg;

    localparam int SPI_BYTE_W    = 8;
    localparam int SPI_ARB_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        WAIT,
        HOLD,
        GAP
    } spi_arb_state_t;

    // A phase of N cycles is a countdown from N-1 to 0.
    function automatic logic [SPI_ARB_CNT_W-1:0] cnt_load(input int cycles);
        return SPI_ARB_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request after the last grant.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx
);

    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(i_last_grant) + k) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = w_cand;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI byte engine between NUM_REQ requesters; owns each granted
// requester's chip select for a whole transaction.
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [SPI_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [SPI_BYTE_W-1:0]         resp_data,
    output logic [NUM_REQ-1:0]            cs_n,
    output logic                          mst_start,
    output logic [SPI_BYTE_W-1:0]         mst_tx_data,
    input  logic                          mst_busy,
    input  logic                          mst_done,
    input  logic [SPI_BYTE_W-1:0]         mst_rx_data
);

    localparam int IDX_W = $clog2(NUM_REQ);

    spi_arb_state_t           r_state;
    logic [SPI_ARB_CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0]         r_g;
    logic [IDX_W-1:0]         r_last_grant;
    logic                     r_last;
    logic [NUM_REQ-1:0]       r_cs_n;
    logic [NUM_REQ-1:0]       r_resp_valid;
    logic [SPI_BYTE_W-1:0]    r_resp_data;

    logic [NUM_REQ-1:0]       w_arb_grant;
    logic [IDX_W-1:0]         w_arb_idx;
    logic                     w_fire;
    logic [SPI_BYTE_W-1:0]    w_tx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant),
        .o_grant_idx  (w_arb_idx)
    );

    assign w_tx = req_data[r_g*SPI_BYTE_W +: SPI_BYTE_W];

    // The byte handoff is combinational so a byte can launch in the first START cycle.
    always_comb begin
        w_fire      = (r_state == START) && req_valid[r_g] && !mst_busy;
        mst_start   = w_fire;
        mst_tx_data = w_fire ? w_tx : '0;
        req_ready   = w_fire ? (NUM_REQ'(1) << r_g) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_g          <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_last       <= 1'b0;
            r_cs_n       <= '1;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        r_g     <= w_arb_idx;
                        r_cs_n  <= ~w_arb_grant;
                        r_cnt   <= cnt_load(CS_SETUP);
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_cnt == '0) r_state <= START;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                START: begin
                    if (w_fire) begin
                        r_last  <= req_last[r_g];
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mst_done) begin
                        r_resp_valid <= NUM_REQ'(1) << r_g;
                        r_resp_data  <= mst_rx_data;
                        if (r_last) begin
                            r_cnt   <= cnt_load(CS_HOLD);
                            r_state <= HOLD;
                        end else begin
                            r_state <= START;
                        end
                    end
                end
                HOLD: begin
                    if (r_cnt == '0) begin
                        r_cs_n       <= '1;
                        r_last_grant <= r_g;
                        r_cnt        <= cnt_load(CS_GAP);
                        r_state      <= GAP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt == '0) r_state <= IDLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cs_n       = r_cs_n;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: byte-engine model, queued requesters and a
// round-robin transaction model that predicts order, data and CS timing.
module tb_spi_master_arbiter;

    localparam int NR       = 2;
    localparam int SU       = 2;
    localparam int HD       = 2;
    localparam int GP       = 1;
    localparam int BYTE_CYC = 3;
    localparam int TO       = 3000;
    localparam int ALL1     = (1 << NR) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   resp_valid;
    logic [7:0]      resp_data;
    logic [NR-1:0]   cs_n;
    logic            mst_start;
    logic [7:0]      mst_tx_data;
    logic            mst_busy;
    logic            mst_done;
    logic [7:0]      mst_rx_data;

    logic            spur_done = 1'b0;
    logic            core_done, core_busy;
    logic [7:0]      core_rx, core_hold;
    int              core_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    spi_master_arbiter #(
        .NUM_REQ (NR), .CS_SETUP (SU), .CS_HOLD (HD), .CS_GAP (GP)
    ) dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_data (req_data), .req_last (req_last),
        .req_ready (req_ready), .resp_valid (resp_valid), .resp_data (resp_data),
        .cs_n (cs_n), .mst_start (mst_start), .mst_tx_data (mst_tx_data),
        .mst_busy (mst_busy), .mst_done (mst_done), .mst_rx_data (mst_rx_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte engine: busy for BYTE_CYC cycles, then done with rx = tx ^ 0x99.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_busy <= 1'b0; core_done <= 1'b0; core_cnt <= 0;
            core_rx <= 8'h00; core_hold <= 8'h00;
        end else begin
            core_done <= 1'b0;
            if (mst_start) begin
                core_busy <= 1'b1;
                core_cnt  <= BYTE_CYC;
                core_hold <= mst_tx_data ^ 8'h99;
            end else if (core_cnt != 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1) begin
                    core_done <= 1'b1;
                    core_busy <= 1'b0;
                    core_rx   <= core_hold;
                end
            end
        end
    end
    assign mst_busy    = core_busy;
    assign mst_done    = core_done | spur_done;
    assign mst_rx_data = core_rx;

    // Requester byte queues (written by the stimulus, drained by the driver).
    int      q_dat  [NR][128];
    bit      q_last [NR][128];
    int      q_gap  [NR][128];
    int      q_tail [NR] = '{default: 0};
    int      q_head [NR] = '{default: 0};
    int      q_wait [NR] = '{default: 0};
    logic [NR-1:0] taken = '0;

    always @(posedge clk) taken <= req_valid & req_ready;

    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (taken[i]) begin
                q_wait[i] = q_gap[i][q_head[i]];
                q_head[i] = q_head[i] + 1;
            end
            if (q_wait[i] != 0) begin
                q_wait[i]    = q_wait[i] - 1;
                req_valid[i] = 1'b0;
            end else if (q_head[i] < q_tail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = q_dat[i][q_head[i]][7:0];
                req_last[i]        = q_last[i][q_head[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    end

    // Event logs and bus invariants, sampled mid-cycle.
    int st_req [512]; int st_dat [512]; int st_t [512]; int st_n = 0;
    int rs_req [512]; int rs_dat [512]; int rs_t [512]; int rs_n = 0;
    int cv_val [512]; int cv_t [512]; int cv_n = 0;
    logic [NR-1:0] cs_prev = '1;
    int viol = 0;

    function automatic int idx_of(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        #2;
        if (mst_start) begin
            st_req[st_n] = idx_of(~cs_n); st_dat[st_n] = int'(mst_tx_data);
            st_t[st_n] = cyc; st_n = st_n + 1;
        end
        if (|resp_valid) begin
            rs_req[rs_n] = idx_of(resp_valid); rs_dat[rs_n] = int'(resp_data);
            rs_t[rs_n] = cyc; rs_n = rs_n + 1;
        end
        if (cs_n != cs_prev) begin
            cv_val[cv_n] = int'(cs_n); cv_t[cv_n] = cyc; cv_n = cv_n + 1;
            cs_prev = cs_n;
        end
        if ($countones(~cs_n) > 1) viol = viol + 1;
        if (mst_start !== (|req_ready)) viol = viol + 1;
        if ((|req_ready) && (req_ready !== ~cs_n)) viol = viol + 1;
        if ((|resp_valid) && (resp_valid !== ~cs_n)) viol = viol + 1;
    end

    // Transaction model: per-requester lists of transactions.
    int m_b   [NR][32][8];
    int m_g   [NR][32][8];
    int m_len [NR][32] = '{default: '{default: 0}};
    int m_ntr [NR] = '{default: 0};
    int m_ptr [NR] = '{default: 0};
    int m_lastg = NR - 1;

    int e_req [256]; int e_dat [256]; int e_gap [256]; bit e_last [256];
    int e_tr_req [64]; int e_tr_first [64]; int e_tr_last [64];
    int ph_st_b, ph_rs_b, ph_cv_b;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic add_byte(input int r, input int d, input bit last, input int gap);
        q_dat[r][q_tail[r]]  = d;
        q_last[r][q_tail[r]] = last;
        q_gap[r][q_tail[r]]  = gap;
        q_tail[r]++;
        m_b[r][m_ntr[r]][m_len[r][m_ntr[r]]] = d;
        m_g[r][m_ntr[r]][m_len[r][m_ntr[r]]] = gap;
        m_len[r][m_ntr[r]]++;
        if (last) m_ntr[r]++;
    endtask

    task automatic tick;
        @(negedge clk); #3;
    endtask

    task automatic run_phase(input string name);
        int ptr [NR];
        int lastg, ntr, ne, r, w, len, f, rz;
        bit found;
        ph_st_b = st_n; ph_rs_b = rs_n; ph_cv_b = cv_n;
        lastg = m_lastg; ntr = 0; ne = 0; r = 0;
        for (int i = 0; i < NR; i++) ptr[i] = m_ptr[i];
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int k = 1; k <= NR && !found; k++) begin
                r = (lastg + k) % NR;
                if (ptr[r] < m_ntr[r]) found = 1'b1;
            end
            if (found) begin
                len = m_len[r][ptr[r]];
                e_tr_req[ntr] = r; e_tr_first[ntr] = ne;
                for (int b = 0; b < len; b++) begin
                    e_req[ne] = r; e_dat[ne] = m_b[r][ptr[r]][b];
                    e_gap[ne] = m_g[r][ptr[r]][b]; e_last[ne] = (b == len - 1);
                    ne++;
                end
                e_tr_last[ntr] = ne - 1;
                ntr++; ptr[r]++; lastg = r;
            end
        end
        w = 0;
        while (((st_n - ph_st_b) < ne || (rs_n - ph_rs_b) < ne || cs_n !== '1) && w < TO) begin
            tick(); w++;
        end
        repeat (GP + 3) tick();
        chk({name, "_timeout"}, int'(w < TO), 1);
        chk({name, "_nstart"}, st_n - ph_st_b, ne);
        chk({name, "_nresp"}, rs_n - ph_rs_b, ne);
        chk({name, "_ncs"}, cv_n - ph_cv_b, 2 * ntr);
        if ((st_n - ph_st_b) == ne && (rs_n - ph_rs_b) == ne && (cv_n - ph_cv_b) == 2 * ntr) begin
            for (int k = 0; k < ne; k++) begin
                chk({name, "_st_req"}, st_req[ph_st_b + k], e_req[k]);
                chk({name, "_st_dat"}, st_dat[ph_st_b + k], e_dat[k]);
                chk({name, "_rs_req"}, rs_req[ph_rs_b + k], e_req[k]);
                chk({name, "_rs_dat"}, rs_dat[ph_rs_b + k], e_dat[k] ^ 'h99);
                chk({name, "_rs_lat"}, rs_t[ph_rs_b + k] - st_t[ph_st_b + k], BYTE_CYC + 2);
                if (!e_last[k])
                    chk({name, "_b2b"}, st_t[ph_st_b + k + 1] - st_t[ph_st_b + k],
                        imax(BYTE_CYC + 2, e_gap[k] + 1));
            end
            for (int j = 0; j < ntr; j++) begin
                f  = ph_cv_b + 2 * j;
                rz = f + 1;
                chk({name, "_cs_low"}, cv_val[f], ALL1 ^ (1 << e_tr_req[j]));
                chk({name, "_cs_high"}, cv_val[rz], ALL1);
                chk({name, "_setup"}, st_t[ph_st_b + e_tr_first[j]] - cv_t[f], SU);
                chk({name, "_hold"}, cv_t[rz] - rs_t[ph_rs_b + e_tr_last[j]], HD);
                if (j > 0) chk({name, "_gap"}, int'((cv_t[f] - cv_t[f - 1]) >= GP + 1), 1);
            end
        end
        for (int i = 0; i < NR; i++) m_ptr[i] = ptr[i];
        m_lastg = lastg;
    endtask

    initial begin
        int sb, rb, cb, w, n, r;
        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cs_n", int'(cs_n), ALL1);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_start", int'(mst_start), 0);
        chk("rst_txdata", int'(mst_tx_data), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_resp_data", int'(resp_data), 0);
        rst = 1'b0;
        repeat (2) tick();

        // Single byte from requester 0
        add_byte(0, 'hA5, 1'b1, 0);
        run_phase("single");
        chk("single_rx", rs_dat[ph_rs_b], 'h3C);
        chk("single_cs_len", cv_t[ph_cv_b + 1] - cv_t[ph_cv_b], SU + BYTE_CYC + 1 + HD + 1);

        // Spurious done while idle
        sb = st_n; rb = rs_n; cb = cv_n;
        tick(); spur_done = 1'b1; tick(); spur_done = 1'b0;
        repeat (5) tick();
        chk("spur_resp", rs_n, rb);
        chk("spur_start", st_n, sb);
        chk("spur_cs_evt", cv_n, cb);
        chk("spur_cs_n", int'(cs_n), ALL1);

        // Multi-byte from requester 1
        add_byte(1, 'h01, 1'b0, 0);
        add_byte(1, 'h02, 1'b0, 0);
        add_byte(1, 'h03, 1'b1, 0);
        run_phase("multi");

        // Contention: two transactions for 0, one two-byte for 1
        add_byte(0, int'($urandom_range(0, 255)), 1'b1, 0);
        add_byte(0, int'($urandom_range(0, 255)), 1'b1, 0);
        add_byte(1, int'($urandom_range(0, 255)), 1'b0, 0);
        add_byte(1, int'($urandom_range(0, 255)), 1'b1, 0);
        run_phase("contend");

        // Stall: requester 0 drops valid for 10 cycles after its first byte
        add_byte(0, 'h11, 1'b0, 10);
        add_byte(0, 'h22, 1'b0, 0);
        add_byte(0, 'h33, 1'b1, 0);
        run_phase("stall");

        // Reset during WAIT
        add_byte(1, 'h5A, 1'b1, 0);
        sb = st_n; rb = rs_n; w = 0;
        while (st_n == sb && w < TO) begin tick(); w++; end
        chk("mid_timeout", int'(w < TO), 1);
        tick();
        chk("mid_cs_before", int'(cs_n), ALL1 ^ 2);
        rst = 1'b1;
        #1;
        chk("mid_cs_n", int'(cs_n), ALL1);
        chk("mid_ready", int'(req_ready), 0);
        chk("mid_start", int'(mst_start), 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("mid_no_resp", rs_n, rb);
        m_ptr[1] = m_ntr[1];
        m_lastg  = NR - 1;
        add_byte(1, 'h66, 1'b1, 0);
        add_byte(0, 'h77, 1'b1, 0);
        run_phase("after_rst");
        chk("after_rst_first", st_req[ph_st_b], 0);

        // Randomized transactions
        for (int t = 0; t < 8; t++) begin
            r = int'($urandom_range(0, NR - 1));
            n = int'($urandom_range(1, 4));
            for (int b = 0; b < n; b++)
                add_byte(r, int'($urandom_range(0, 255)), (b == n - 1),
                         (b == n - 1) ? 0 : int'($urandom_range(0, 3)));
        end
        run_phase("random");

        chk("bus_invariants", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
